// File: rtl/iis_tx_if.sv
// -----------------------------------------------------------------------------
// iis_tx_if
// Bundles the audio-source stream signals and the I2S transmitter data-load
// signals that iis_tx_arbiter sits between.
//
//   src_req     [N_SRC]      session request per source, level-held
//   src_data_l  [N_SRC*32]   left sample of source i at [32i+31:32i], signed
//   src_data_r  [N_SRC*32]   right sample, same packing
//   src_valid   [N_SRC]      sample pair valid
//   src_ready   [N_SRC]      sample pair accepted when valid & ready
//   frame_rd    [1]          one-cycle frame pulse from the transmitter (data_rd)
//   tx_data_l   [32]         left sample to the transmitter
//   tx_data_r   [32]         right sample to the transmitter
//
// Modports:
//   master - the environment: sources plus transmitter (drives requests,
//            samples and frame_rd; observes ready and tx data)
//   slave  - the arbiter
// -----------------------------------------------------------------------------
interface iis_tx_if #(
    parameter int N_SRC = 2
);
    logic [N_SRC-1:0]    src_req;
    logic [N_SRC*32-1:0] src_data_l;
    logic [N_SRC*32-1:0] src_data_r;
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC-1:0]    src_ready;
    logic                frame_rd;
    logic [31:0]         tx_data_l;
    logic [31:0]         tx_data_r;

    modport master (
        output src_req,
        output src_data_l,
        output src_data_r,
        output src_valid,
        output frame_rd,
        input  src_ready,
        input  tx_data_l,
        input  tx_data_r
    );

    modport slave (
        input  src_req,
        input  src_data_l,
        input  src_data_r,
        input  src_valid,
        input  frame_rd,
        output src_ready,
        output tx_data_l,
        output tx_data_r
    );
endinterface

// File: rtl/iis_tx_arbiter.sv
// -----------------------------------------------------------------------------
// iis_tx_arbiter
// Shares one I2S transmitter among N_SRC audio requesters. One source owns the
// transmitter per session, chosen round-robin. Its stereo pairs are buffered in
// a FIFO and one L/R pair is handed to the transmitter per frame_rd pulse.
// Each session runs IDLE -> PREFILL -> RUN -> DRAIN -> IDLE.
//
// Ports:
//   clk           master clock (same clock as the I2S clock generator)
//   rst           synchronous, active-high reset
//   bus           iis_tx_if.slave: source streams, frame_rd, tx_data_l/r
//   grant         one-hot current owner, all zero in IDLE
//   state         0 IDLE, 1 PREFILL, 2 RUN, 3 DRAIN
//   fifo_level    current FIFO occupancy (0..FIFO_DEPTH)
//   underrun_cnt  saturating count of frames that found the FIFO empty in RUN
//
// Parameters:
//   N_SRC       number of requesters (1..8)
//   FIFO_DEPTH  sample-pair FIFO depth (power of two, >= 2)
//   PREFILL     FIFO level needed to leave PREFILL (1..FIFO_DEPTH)
//   CNT_W       underrun counter width
//
// Build option:
//   IIS_ARB_HOLD_LAST_EN  when defined, a RUN underrun repeats the previous
//                         tx_data_l/r pair; otherwise it outputs zero.
// -----------------------------------------------------------------------------
module iis_tx_arbiter #(
    parameter int N_SRC      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int PREFILL    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    iis_tx_if.slave                       bus,
    output logic [N_SRC-1:0]              grant,
    output logic [1:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    localparam logic [PW-1:0] LAST_SRC  = PW'(N_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,  state_nx;
    logic [N_SRC-1:0]   grant_q,  grant_nx;
    logic [PW-1:0]      owner_q,  owner_nx;   // binary index of the owner
    logic [PW-1:0]      rr_q,     rr_nx;      // round-robin search start

    logic [63:0]        mem [FIFO_DEPTH];     // {left, right} per entry
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q,  level_nx;

    logic [31:0]        tx_l_q,   tx_l_nx;
    logic [31:0]        tx_r_q,   tx_r_nx;
    logic [CNT_W-1:0]   urun_q;

    // -------------------------------------------------------------------------
    // Owner view of the source bus
    // -------------------------------------------------------------------------
    logic        owner_req;
    logic        owner_valid;
    logic [31:0] owner_l;
    logic [31:0] owner_r;

    assign owner_req   = bus.src_req[owner_q];
    assign owner_valid = bus.src_valid[owner_q];
    assign owner_l     = bus.src_data_l[int'(owner_q) * 32 +: 32];
    assign owner_r     = bus.src_data_r[int'(owner_q) * 32 +: 32];

    // Ready depends only on registered state, never on src_valid, so a source
    // may legally wait for ready before raising valid.
    logic accepting;
    logic push;

    assign accepting     = ((state_q == ST_PREFILL) || (state_q == ST_RUN)) &&
                           (level_q != DEPTH_L);
    assign bus.src_ready = grant_q & {N_SRC{accepting}};
    assign push          = accepting & owner_valid;

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_q, wrapping
    // -------------------------------------------------------------------------
    logic          pick_any;
    logic [PW-1:0] pick_idx;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!pick_any && bus.src_req[(int'(rr_q) + k) % N_SRC]) begin
                pick_any = 1'b1;
                pick_idx = PW'((int'(rr_q) + k) % N_SRC);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, FIFO control and frame handling
    // -------------------------------------------------------------------------
    logic pop;
    logic underrun;

    always_comb begin
        state_nx = state_q;
        grant_nx = grant_q;
        owner_nx = owner_q;
        rr_nx    = rr_q;
        pop      = 1'b0;
        underrun = 1'b0;
        tx_l_nx  = tx_l_q;
        tx_r_nx  = tx_r_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx           = ST_PREFILL;
                    grant_nx           = '0;
                    grant_nx[pick_idx] = 1'b1;
                    owner_nx           = pick_idx;
                    rr_nx              = (pick_idx == LAST_SRC) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_PREFILL: begin
                // A source that withdraws before the FIFO primes goes straight
                // to DRAIN so whatever it already pushed is still played out.
                if (!owner_req) begin
                    state_nx = ST_DRAIN;
                end else if (level_q >= PREFILL_L) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!owner_req) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.frame_rd && (level_q == '0)) begin
                    state_nx = ST_IDLE;
                    grant_nx = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase

        // One pair per frame. An empty FIFO in DRAIN is the end of session,
        // not an underrun; in IDLE/PREFILL the transmitter is fed silence.
        if (bus.frame_rd) begin
            if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (level_q != '0)) begin
                pop     = 1'b1;
                tx_l_nx = mem[rd_ptr_q][63:32];
                tx_r_nx = mem[rd_ptr_q][31:0];
            end else if (state_q == ST_RUN) begin
                underrun = 1'b1;
`ifdef IIS_ARB_HOLD_LAST_EN
                tx_l_nx  = tx_l_q;
                tx_r_nx  = tx_r_q;
`else
                tx_l_nx  = '0;
                tx_r_nx  = '0;
`endif
            end else begin
                tx_l_nx = '0;
                tx_r_nx = '0;
            end
        end

        // Push is blocked when full and pop is blocked when empty, so the
        // level stays within 0..FIFO_DEPTH; an empty-FIFO pop attempt plus a
        // push simply keeps the pushed pair.
        case ({push, pop})
            2'b10:   level_nx = level_q + 1'b1;
            2'b01:   level_nx = level_q - 1'b1;
            default: level_nx = level_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_nx;
            grant_q <= grant_nx;
            owner_q <= owner_nx;
            rr_q    <= rr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tx_l_q   <= '0;
            tx_r_q   <= '0;
            urun_q   <= '0;
        end else begin
            level_q <= level_nx;
            tx_l_q  <= tx_l_nx;
            tx_r_q  <= tx_r_nx;
            // Depth is a power of two, so pointer wrap is the natural overflow.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (underrun && (urun_q != '1)) begin
                urun_q <= urun_q + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {owner_l, owner_r};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign grant         = grant_q;
    assign state         = state_q;
    assign fifo_level    = level_q;
    assign underrun_cnt  = urun_q;
    assign bus.tx_data_l = tx_l_q;
    assign bus.tx_data_r = tx_r_q;

endmodule
